// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter: each requester has a 2-entry FIFO, one pop per cycle.
// Macro RF_WARB_RR_EN selects round-robin arbitration; left undefined, requester 0 has fixed priority.
module regfile_write_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        rf_regwrite,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd3,
  output logic        err_r0,
  output logic [1:0]  pend
);

  localparam int unsigned AddrW  = 5;
  localparam int unsigned DataW  = 32;
  localparam int unsigned EntryW = AddrW + DataW;
  localparam int unsigned Depth  = 2;

  typedef logic [EntryW-1:0] entry_t;

  entry_t     mem_q    [2][Depth];
  logic [1:0] cnt_q    [2];
  logic       wr_ptr_q [2];
  logic       rd_ptr_q [2];
  logic       prio_q;
  logic       prio_d;

  logic       regwrite_q;
  logic [4:0] a3_q;
  logic [31:0] wd3_q;
  logic       err_r0_q;

  logic [1:0] valid;
  entry_t     in_entry [2];
  logic [1:0] nonempty;
  logic [1:0] full;
  logic [1:0] push;
  logic [1:0] pop;
  logic       pop_any;
  logic       pop_sel;
  entry_t     pop_entry;
  logic       pop_is_r0;

  always_comb begin
    valid       = {req1_valid, req0_valid};
    in_entry[0] = {req0_addr, req0_data};
    in_entry[1] = {req1_addr, req1_data};
    for (int n = 0; n < 2; n++) begin
      nonempty[n] = (cnt_q[n] != 2'd0);
      full[n]     = (cnt_q[n] == 2'd2);
      push[n]     = valid[n] && !full[n];
    end
  end

  // Arbitration looks only at registered occupancy, so an entry pushed this cycle cannot pop.
  always_comb begin
    pop_any   = |nonempty;
    pop_sel   = (nonempty[0] && nonempty[1]) ? prio_q : nonempty[1];
    pop[0]    = pop_any && !pop_sel;
    pop[1]    = pop_any && pop_sel;
    pop_entry = mem_q[pop_sel][rd_ptr_q[pop_sel]];
    pop_is_r0 = (pop_entry[EntryW-1:DataW] == 5'd0);
  end

  always_comb begin
`ifdef RF_WARB_RR_EN
    prio_d = pop_any ? ~pop_sel : prio_q;
`else
    prio_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) begin
        for (int i = 0; i < int'(Depth); i++) begin
          mem_q[n][i] <= '0;
        end
        cnt_q[n]    <= 2'd0;
        wr_ptr_q[n] <= 1'b0;
        rd_ptr_q[n] <= 1'b0;
      end
      prio_q <= 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push[n]) begin
          mem_q[n][wr_ptr_q[n]] <= in_entry[n];
          wr_ptr_q[n]           <= ~wr_ptr_q[n];
        end
        if (pop[n]) begin
          rd_ptr_q[n] <= ~rd_ptr_q[n];
        end
        cnt_q[n] <= cnt_q[n] + {1'b0, push[n]} - {1'b0, pop[n]};
      end
      prio_q <= prio_d;
    end
  end

  // Output stage: a popped register-0 write becomes an error pulse instead of a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_q <= 1'b0;
      a3_q       <= '0;
      wd3_q      <= '0;
      err_r0_q   <= 1'b0;
    end else begin
      regwrite_q <= pop_any && !pop_is_r0;
      err_r0_q   <= pop_any && pop_is_r0;
      if (pop_any) begin
        a3_q  <= pop_entry[EntryW-1:DataW];
        wd3_q <= pop_entry[DataW-1:0];
      end
    end
  end

  assign req0_ready  = !full[0];
  assign req1_ready  = !full[1];
  assign pend        = nonempty;
  assign rf_regwrite = regwrite_q;
  assign rf_a3       = a3_q;
  assign rf_wd3      = wd3_q;
  assign err_r0      = err_r0_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: queue-based reference model, directed and random phases.
// Honours RF_WARB_RR_EN in its model, matching the build of the design.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_regwrite;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic        err_r0;
  logic [1:0]  pend;

  regfile_write_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .rf_regwrite(rf_regwrite),
    .rf_a3      (rf_a3),
    .rf_wd3     (rf_wd3),
    .err_r0     (err_r0),
    .pend       (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: one queue per requester, plus the queue of entries expected at the output.
  logic [36:0] m_q0[$];
  logic [36:0] m_q1[$];
  logic [36:0] exp_q[$];
  logic [36:0] obs_q[$];
  bit          m_prio;
  bit          m_popped;
  bit          acc0, acc1;
  bit          r0_ok, r1_ok, sel;
  int          err_cnt = 0;
  int          wr_cnt  = 0;

  always @(posedge clk) begin
    if (rst_n) begin
      r0_ok    = m_q0.size() < 2;
      r1_ok    = m_q1.size() < 2;
      m_popped = 1'b0;
      if (m_q0.size() != 0 || m_q1.size() != 0) begin
        sel = (m_q0.size() != 0 && m_q1.size() != 0) ? m_prio : (m_q0.size() == 0);
        if (sel) exp_q.push_back(m_q1.pop_front());
        else     exp_q.push_back(m_q0.pop_front());
        m_popped = 1'b1;
`ifdef RF_WARB_RR_EN
        m_prio = ~sel;
`endif
      end
      acc0 = req0_valid && r0_ok;
      acc1 = req1_valid && r1_ok;
      if (acc0) m_q0.push_back({req0_addr, req0_data});
      if (acc1) m_q1.push_back({req1_addr, req1_data});
    end
  end

  // Monitor: compare DUT state and outputs against the model on the falling edge.
  logic [36:0] e;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("req0_ready", req0_ready, m_q0.size() < 2);
      chk("req1_ready", req1_ready, m_q1.size() < 2);
      chk("pend", pend, {m_q1.size() != 0, m_q0.size() != 0});
      chk("out_valid", rf_regwrite | err_r0, m_popped);
      if (m_popped && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e[36:32] == 5'd0) begin
          chk("r0_discard", {rf_regwrite, err_r0}, 2'b01);
        end else begin
          chk("wr_en", {rf_regwrite, err_r0}, 2'b10);
          chk("wr_addr", rf_a3, e[36:32]);
          chk("wr_data", rf_wd3, e[31:0]);
        end
      end
      if (rf_regwrite) begin
        obs_q.push_back({rf_a3, rf_wd3});
        wr_cnt++;
      end
      if (err_r0) err_cnt++;
    end
  end

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    m_q0.delete(); m_q1.delete(); exp_q.delete();
    m_prio = 1'b0; m_popped = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_regwrite", rf_regwrite, 0);
    chk("rst_a3", rf_a3, 0);
    chk("rst_wd3", rf_wd3, 0);
    chk("rst_err_r0", err_r0, 0);
    chk("rst_pend", pend, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 2'b11);
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0);
    repeat (n) @(negedge clk);
  endtask

  logic [36:0] want[4];
  logic [31:0] xd[3];
  int          xi, waited, base_err, base_wr;

  initial begin
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    assert_reset();
    idle(2);

    // Single write: visible in the cycle after the second edge, then gone.
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    chk("single_not_early", rf_regwrite, 0);
    @(negedge clk);
    chk("single_we", rf_regwrite, 1);
    chk("single_a3", rf_a3, 5);
    chk("single_wd3", rf_wd3, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_we_drop", rf_regwrite, 0);
    chk("single_a3_hold", rf_a3, 5);
    idle(3);

    // Contention ordering.
    obs_q.delete();
    drive(1, 1, 32'hA1, 1, 3, 32'hB1);
    @(negedge clk); drive(1, 2, 32'hA2, 1, 4, 32'hB2);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    idle(6);
`ifdef RF_WARB_RR_EN
    want[0] = {5'd1, 32'hA1}; want[1] = {5'd3, 32'hB1};
    want[2] = {5'd2, 32'hA2}; want[3] = {5'd4, 32'hB2};
`else
    want[0] = {5'd1, 32'hA1}; want[1] = {5'd2, 32'hA2};
    want[2] = {5'd3, 32'hB1}; want[3] = {5'd4, 32'hB2};
`endif
    chk("order_count", obs_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs_q.size()) chk($sformatf("order_%0d", i), obs_q[i], want[i]);
    end

    // Full FIFO on requester 1 while requester 0 keeps the arbiter busy.
    xd[0] = 32'h1111_0001; xd[1] = 32'h1111_0002; xd[2] = 32'h1111_0003;
    xi = 0;
    drive(1, 9, 32'h0, 1, 10, xd[0]);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (acc1 && xi < 3) xi++;
      drive(1, 9, c, 1, 10, xd[(xi < 3) ? xi : 2]);
`ifndef RF_WARB_RR_EN
      if (c >= 2) begin
        chk("full_ready_low", req1_ready, 0);
        chk("full_accepts", xi, 2);
      end
`endif
    end
    req0_valid = 1'b0;
    waited = 0;
    while (xi < 3 && waited < 20) begin
      @(negedge clk);
      if (acc1) xi++;
      waited++;
    end
    chk("full_third_accepted", xi, 3);
    idle(10);

    // Register-0 write is dropped with a single error pulse; the next write proceeds.
    obs_q.delete();
    base_err = err_cnt;
    drive(1, 0, 32'h12345678, 0, 0, 0);
    @(negedge clk); drive(1, 7, 32'hCAFEF00D, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    idle(5);
    chk("r0_err_pulses", err_cnt - base_err, 1);
    chk("r0_next_count", obs_q.size(), 1);
    if (obs_q.size() != 0) chk("r0_next_write", obs_q[0], {5'd7, 32'hCAFEF00D});

    // Reset with three entries queued and one write in the output stage.
    drive(1, 11, 32'hE1, 1, 12, 32'hF1);
    @(negedge clk); drive(1, 13, 32'hE2, 1, 14, 32'hF2);
    @(posedge clk); #3;
    chk("pre_rst_regwrite", rf_regwrite, 1);
    chk("pre_rst_pend", pend, 2'b11);
    assert_reset();
    base_wr = wr_cnt;
    idle(6);
    chk("post_rst_no_write", wr_cnt - base_wr, 0);

    // Randomised traffic; requesters hold an offer until it is accepted.
    for (int c = 0; c < 1500; c++) begin
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 99) < 60);
        req0_addr  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        req0_data  = $urandom;
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 99) < 60);
        req1_addr  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        req1_data  = $urandom;
      end
      @(negedge clk);
    end
    idle(10);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester n offers a write.
REQ-004 SHALL have ports req0_addr and req1_addr, input, 5 bits each: destination register.
REQ-005 SHALL have ports req0_data and req1_data, input, 32 bits each: write data.
REQ-006 SHALL have ports req0_ready and req1_ready, output, 1 bit each: requester n's FIFO can accept an entry.
REQ-007 SHALL have port rf_regwrite, output, 1 bit: register-file write enable.
REQ-008 SHALL have port rf_a3, output, 5 bits: register-file write address.
REQ-009 SHALL have port rf_wd3, output, 32 bits: register-file write data.
REQ-010 SHALL have port err_r0, output, 1 bit: one-cycle pulse when a write to register 0 is discarded.
REQ-011 SHALL have port pend, output, 2 bits: bit n is set when requester n's FIFO is non-empty.

Function
REQ-012 SHALL give each requester its own 2-entry FIFO holding {addr, data}; reqN_ready = FIFO not full.
REQ-013 SHALL push on reqN_valid && reqN_ready at a rising edge; valid without ready is ignored, and the requester holds its request.
REQ-014 SHALL pop at most one entry per cycle in total, from the FIFO selected by the arbiter.
REQ-015 SHALL register the popped entry onto rf_regwrite/rf_a3/rf_wd3, so it appears one cycle after the pop edge and rf_regwrite is high for exactly one cycle per entry.
REQ-016 SHALL deassert rf_regwrite on cycles with no pop; rf_a3 and rf_wd3 then hold their last values.
REQ-017 SHALL discard a popped entry with addr 0: rf_regwrite stays 0 and err_r0 pulses 1 in the cycle rf_regwrite would have asserted.
REQ-018 SHALL allow a push and a pop on the same FIFO in one cycle; the count is unchanged. A FIFO with count 0 cannot pop in the same cycle it is pushed (no bypass; minimum latency from accept to rf_regwrite is 2 cycles).
REQ-019 SHALL keep the FIFOs first-in first-out, so same-requester writes reach the register file in acceptance order.
REQ-020 SHALL keep a 1-bit priority pointer (0 = requester 0 preferred). When both FIFOs are non-empty, the arbiter pops the preferred one; when one is non-empty, it pops that one.
REQ-021 SHALL update the priority pointer after each pop according to REQ-026.
REQ-022 SHALL drive pend directly from the FIFO occupancy as registered state.

Reset
REQ-023 SHALL, on rst_n low and asynchronously, clear both FIFOs (count 0, pointers 0), set the priority pointer to 0, and clear rf_regwrite, rf_a3, rf_wd3, err_r0 and pend to 0.
REQ-024 SHALL assert req0_ready and req1_ready as 1 while in reset and after reset, since the FIFOs are empty.
REQ-025 SHALL discard FIFO contents and any write in the output stage if reset asserts mid-operation; no rf_regwrite pulse follows reset release until a new entry is popped.

Configuration
REQ-026 SHALL support macro RF_WARB_RR_EN, with behaviour as follows:
- Defined: round-robin; after a pop from requester n, the pointer becomes 1-n.
- Undefined: fixed priority; the pointer stays 0 permanently, and requester 1 is served only when requester 0's FIFO is empty.

Verification
REQ-027 SHALL cover single write: req0 pushes addr 5, data 0xDEADBEEF at edge 1 -> rf_regwrite=1, rf_a3=5, rf_wd3=0xDEADBEEF during cycle after edge 2, then 0.
REQ-028 SHALL cover contention: both FIFOs hold 2 entries (r0: A1,A2; r1: B1,B2) -> output order:
- with RF_WARB_RR_EN, A1,B1,A2,B2;
- without RF_WARB_RR_EN, A1,A2,B1,B2.
REQ-029 SHALL cover full FIFO: req1_valid held high with no pops (req0 always pending, fixed priority) -> req1_ready falls after 2 accepts; the third request is held, not lost.
REQ-030 SHALL cover register 0: push addr 0, data 0x12345678 -> err_r0 pulses once, rf_regwrite stays 0, and the next entry is written normally.
REQ-031 SHALL cover reset mid-flight: rst_n low with 3 entries queued and one in the output stage -> all outputs 0 immediately, pend=0, both ready=1, and no rf_regwrite after release.
